cphy_lp_state_detector: RTL and testbench

- Consumes the 3-bit C-PHY trio LP line levels after the 2-flop synchronizer, in the slave receive clock domain.
- Glitch-filters the LP levels and tracks the LP stop / HS-request / bridge entry sequence.
- Produces the enable that arms the HS receive datapath, plus entry/exit/error pulses for the lane controller.

---
 rtl/cphy_lp_pkg.sv | 16 +
 rtl/cphy_lp_glitch_filter.sv | 45 ++++
 rtl/cphy_lp_state_detector.sv | 119 +++++++++++
 tb/tb_cphy_lp_state_detector.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cphy_lp_pkg.sv
// Shared LP line codes and detector state encoding for the C-PHY trio LP state detector.
package cphy_lp_pkg;

   localparam logic [2:0] LP_STOP    = 3'b111;
   localparam logic [2:0] LP_HS_RQST = 3'b001;
   localparam logic [2:0] LP_BRIDGE  = 3'b000;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_STOP    = 3'd1,
      ST_HS_RQST = 3'd2,
      ST_HS_PREP = 3'd3,
      ST_HS      = 3'd4
   } lp_fsm_t;

endpackage

// File: rtl/cphy_lp_glitch_filter.sv
// Accepts a new LP level only after FILTER_CYCLES consecutive identical samples
// that differ from the currently accepted level.
module cphy_lp_glitch_filter
   import cphy_lp_pkg::*;
#(
   parameter int FILTER_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] lp_in,
   output logic [2:0] lp_state
);

   localparam logic [3:0] FC = 4'(FILTER_CYCLES);

   logic [2:0] cand;
   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lp_state <= LP_STOP;
         cand     <= LP_STOP;
         cnt      <= 4'd0;
      end else if (lp_in == lp_state) begin
         cnt <= 4'd0;
      end else if (cnt != 4'd0 && lp_in == cand) begin
         if (cnt + 4'd1 == FC) begin
            lp_state <= lp_in;
            cnt      <= 4'd0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end else begin
         // First sample of a new candidate; a run length of one accepts immediately.
         cand <= lp_in;
         if (FC == 4'd1) begin
            lp_state <= lp_in;
            cnt      <= 4'd0;
         end else begin
            cnt <= 4'd1;
         end
      end
   end

endmodule

// File: rtl/cphy_lp_state_detector.sv
// C-PHY trio LP state detector: glitch-filters the LP levels and walks the
// STOP -> HS-request -> bridge -> HS sequence to arm the HS receiver.
module cphy_lp_state_detector
   import cphy_lp_pkg::*;
#(
   parameter int FILTER_CYCLES    = 4,
   parameter int HS_SETTLE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [2:0] lp_in,
   output logic [2:0] lp_state,
   output logic       stop_state,
   output logic       hs_rx_en,
   output logic       hs_entry_pulse,
   output logic       hs_exit_pulse,
   output logic       lp_err
);

   localparam logic [7:0] SETTLE_LAST = 8'(HS_SETTLE_CYCLES - 1);

   lp_fsm_t    state;
   logic [7:0] settle;

   cphy_lp_glitch_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .lp_in    (lp_in),
      .lp_state (lp_state)
   );

   // Decoded outputs are assigned alongside every transition so they stay registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_INIT;
         settle         <= 8'd0;
         stop_state     <= 1'b0;
         hs_rx_en       <= 1'b0;
         hs_entry_pulse <= 1'b0;
         hs_exit_pulse  <= 1'b0;
         lp_err         <= 1'b0;
      end else begin
         hs_entry_pulse <= 1'b0;
         hs_exit_pulse  <= 1'b0;
         lp_err         <= 1'b0;
         if (!enable) begin
            state      <= ST_INIT;
            stop_state <= 1'b0;
            hs_rx_en   <= 1'b0;
         end else begin
            case (state)
               ST_INIT: begin
                  if (lp_state == LP_STOP) begin
                     state      <= ST_STOP;
                     stop_state <= 1'b1;
                  end
               end
               ST_STOP: begin
                  if (lp_state == LP_HS_RQST) begin
                     state      <= ST_HS_RQST;
                     stop_state <= 1'b0;
                  end else if (lp_state != LP_STOP) begin
                     state      <= ST_INIT;
                     stop_state <= 1'b0;
                     lp_err     <= 1'b1;
                  end
               end
               ST_HS_RQST: begin
                  if (lp_state == LP_BRIDGE) begin
                     state  <= ST_HS_PREP;
                     settle <= 8'd0;
                  end else if (lp_state == LP_STOP) begin
                     state      <= ST_STOP;
                     stop_state <= 1'b1;
                  end else if (lp_state != LP_HS_RQST) begin
                     state  <= ST_INIT;
                     lp_err <= 1'b1;
                  end
               end
               ST_HS_PREP: begin
                  // Leaving the bridge on the terminal count takes priority over HS entry.
                  if (lp_state == LP_BRIDGE) begin
                     if (settle == SETTLE_LAST) begin
                        state          <= ST_HS;
                        hs_rx_en       <= 1'b1;
                        hs_entry_pulse <= 1'b1;
                     end else begin
                        settle <= settle + 8'd1;
                     end
                  end else if (lp_state == LP_STOP) begin
                     state      <= ST_STOP;
                     stop_state <= 1'b1;
                  end else begin
                     state  <= ST_INIT;
                     lp_err <= 1'b1;
                  end
               end
               ST_HS: begin
                  if (lp_state == LP_STOP) begin
                     state         <= ST_STOP;
                     stop_state    <= 1'b1;
                     hs_rx_en      <= 1'b0;
                     hs_exit_pulse <= 1'b1;
                  end
               end
               default: begin
                  state      <= ST_INIT;
                  stop_state <= 1'b0;
                  hs_rx_en   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cphy_lp_state_detector.sv
// Bench for the C-PHY LP state detector: an event scoreboard plus per-scenario latency checks.
module tb_cphy_lp_state_detector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [2:0] lp_in;
   logic [2:0] lp_state;
   logic       stop_state;
   logic       hs_rx_en;
   logic       hs_entry_pulse;
   logic       hs_exit_pulse;
   logic       lp_err;

   int total = 0;
   int bad   = 0;

   // Event codes: {kind, 1'b0, lp value}. Kinds are listed in the order the
   // monitor reports them within a single cycle.
   localparam logic [3:0] K_LP    = 4'd1;
   localparam logic [3:0] K_SRISE = 4'd2;
   localparam logic [3:0] K_SFALL = 4'd3;
   localparam logic [3:0] K_HRISE = 4'd4;
   localparam logic [3:0] K_HFALL = 4'd5;
   localparam logic [3:0] K_ENTRY = 4'd6;
   localparam logic [3:0] K_EXIT  = 4'd7;
   localparam logic [3:0] K_ERR   = 4'd8;

   logic [7:0] exp_q[$];
   logic [2:0] p_lp;
   logic       p_stop;
   logic       p_hs;

   cphy_lp_state_detector #(
      .FILTER_CYCLES    (4),
      .HS_SETTLE_CYCLES (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .lp_in          (lp_in),
      .lp_state       (lp_state),
      .stop_state     (stop_state),
      .hs_rx_en       (hs_rx_en),
      .hs_entry_pulse (hs_entry_pulse),
      .hs_exit_pulse  (hs_exit_pulse),
      .lp_err         (lp_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ev(input logic [3:0] k, input logic [2:0] v);
      return {k, 1'b0, v};
   endfunction

   // One clock: let the edge happen, sample on the falling edge, compare observed events in order.
   task automatic cyc();
      logic [7:0] obs[$];
      logic [7:0] e;
      @(posedge clk);
      @(negedge clk);
      if (lp_state !== p_lp)      obs.push_back(ev(K_LP, lp_state));
      if (stop_state && !p_stop)  obs.push_back(ev(K_SRISE, 3'd0));
      if (!stop_state && p_stop)  obs.push_back(ev(K_SFALL, 3'd0));
      if (hs_rx_en && !p_hs)      obs.push_back(ev(K_HRISE, 3'd0));
      if (!hs_rx_en && p_hs)      obs.push_back(ev(K_HFALL, 3'd0));
      if (hs_entry_pulse !== 1'b0) obs.push_back(ev(K_ENTRY, 3'd0));
      if (hs_exit_pulse !== 1'b0)  obs.push_back(ev(K_EXIT, 3'd0));
      if (lp_err !== 1'b0)         obs.push_back(ev(K_ERR, 3'd0));
      foreach (obs[i]) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: observed event %h, required none", obs[i]);
         end else begin
            e = exp_q.pop_front();
            if (obs[i] !== e) begin
               bad++;
               $display("FAIL sb_event: observed %h, required %h", obs[i], e);
            end
         end
      end
      p_lp   = lp_state;
      p_stop = stop_state;
      p_hs   = hs_rx_en;
   endtask

   task automatic hold(input logic [2:0] v, input int n);
      lp_in = v;
      repeat (n) cyc();
   endtask

   task automatic sb_flush(input string name);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_missing_%s: %0d expected events never observed, next %h",
                  name, exp_q.size(), exp_q[0]);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b1;
      lp_in  = 3'b111;
      repeat (3) @(negedge clk);
      total++;
      if (lp_state !== 3'b111) begin
         bad++; $display("FAIL reset_lp_state: got %b, want 111", lp_state);
      end
      total++;
      if ({stop_state, hs_rx_en, hs_entry_pulse, hs_exit_pulse, lp_err} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b, want 00000",
                  {stop_state, hs_rx_en, hs_entry_pulse, hs_exit_pulse, lp_err});
      end
      p_lp = 3'b111; p_stop = 1'b0; p_hs = 1'b0;
      rst_n = 1'b1;
      exp_q.push_back(ev(K_SRISE, 3'd0));
      cyc();
      total++;
      if (stop_state !== 1'b1) begin
         bad++; $display("FAIL reset_to_stop: got %b, want 1", stop_state);
      end
      sb_flush("reset");
   endtask

   task automatic test_normal_entry();
      hold(3'b111, 10);
      exp_q.push_back(ev(K_LP, 3'b001));
      exp_q.push_back(ev(K_SFALL, 3'd0));
      hold(3'b001, 4);
      total++;
      if (stop_state !== 1'b1 || lp_state !== 3'b001) begin
         bad++; $display("FAIL rqst_t3: stop=%b lp=%b, want 1 001", stop_state, lp_state);
      end
      cyc();
      total++;
      if (stop_state !== 1'b0) begin
         bad++; $display("FAIL rqst_t4: stop=%b, want 0", stop_state);
      end
      repeat (5) cyc();
      exp_q.push_back(ev(K_LP, 3'b000));
      exp_q.push_back(ev(K_HRISE, 3'd0));
      exp_q.push_back(ev(K_ENTRY, 3'd0));
      hold(3'b000, 12);
      total++;
      if (hs_rx_en !== 1'b0 || hs_entry_pulse !== 1'b0) begin
         bad++; $display("FAIL entry_m11: hs=%b pulse=%b, want 0 0", hs_rx_en, hs_entry_pulse);
      end
      cyc();
      total++;
      if (hs_rx_en !== 1'b1 || hs_entry_pulse !== 1'b1) begin
         bad++; $display("FAIL entry_m12: hs=%b pulse=%b, want 1 1", hs_rx_en, hs_entry_pulse);
      end
      repeat (7) cyc();
      exp_q.push_back(ev(K_LP, 3'b111));
      exp_q.push_back(ev(K_SRISE, 3'd0));
      exp_q.push_back(ev(K_HFALL, 3'd0));
      exp_q.push_back(ev(K_EXIT, 3'd0));
      hold(3'b111, 4);
      total++;
      if (hs_rx_en !== 1'b1 || stop_state !== 1'b0) begin
         bad++; $display("FAIL exit_e3: hs=%b stop=%b, want 1 0", hs_rx_en, stop_state);
      end
      cyc();
      total++;
      if ({hs_rx_en, stop_state, hs_exit_pulse} !== 3'b011) begin
         bad++;
         $display("FAIL exit_e4: hs/stop/exit=%b, want 011", {hs_rx_en, stop_state, hs_exit_pulse});
      end
      hold(3'b111, 3);
      sb_flush("normal");
   endtask

   task automatic test_glitch();
      hold(3'b001, 3);
      hold(3'b111, 6);
      total++;
      if (lp_state !== 3'b111 || stop_state !== 1'b1) begin
         bad++; $display("FAIL glitch3: lp=%b stop=%b, want 111 1", lp_state, stop_state);
      end
      exp_q.push_back(ev(K_LP, 3'b001));
      exp_q.push_back(ev(K_SFALL, 3'd0));
      exp_q.push_back(ev(K_LP, 3'b111));
      exp_q.push_back(ev(K_SRISE, 3'd0));
      hold(3'b001, 4);
      total++;
      if (lp_state !== 3'b001) begin
         bad++; $display("FAIL glitch4_lp: got %b, want 001", lp_state);
      end
      lp_in = 3'b111;
      cyc();
      total++;
      if (stop_state !== 1'b0) begin
         bad++; $display("FAIL glitch4_rqst: stop=%b, want 0", stop_state);
      end
      hold(3'b111, 5);
      total++;
      if (stop_state !== 1'b1) begin
         bad++; $display("FAIL glitch4_back: stop=%b, want 1", stop_state);
      end
      sb_flush("glitch");
   endtask

   task automatic test_abort();
      exp_q.push_back(ev(K_LP, 3'b001));
      exp_q.push_back(ev(K_SFALL, 3'd0));
      hold(3'b001, 8);
      exp_q.push_back(ev(K_LP, 3'b111));
      exp_q.push_back(ev(K_SRISE, 3'd0));
      hold(3'b000, 3);
      hold(3'b111, 8);
      total++;
      if (stop_state !== 1'b1) begin
         bad++; $display("FAIL abort_rqst: stop=%b, want 1", stop_state);
      end
      exp_q.push_back(ev(K_LP, 3'b001));
      exp_q.push_back(ev(K_SFALL, 3'd0));
      hold(3'b001, 8);
      exp_q.push_back(ev(K_LP, 3'b000));
      exp_q.push_back(ev(K_LP, 3'b111));
      exp_q.push_back(ev(K_SRISE, 3'd0));
      hold(3'b000, 6);
      hold(3'b111, 8);
      total++;
      if (stop_state !== 1'b1 || hs_rx_en !== 1'b0) begin
         bad++; $display("FAIL abort_prep: stop=%b hs=%b, want 1 0", stop_state, hs_rx_en);
      end
      sb_flush("abort");
   endtask

   task automatic test_illegal();
      exp_q.push_back(ev(K_LP, 3'b010));
      exp_q.push_back(ev(K_SFALL, 3'd0));
      exp_q.push_back(ev(K_ERR, 3'd0));
      hold(3'b010, 6);
      total++;
      if (stop_state !== 1'b0 || lp_err !== 1'b0) begin
         bad++; $display("FAIL illegal_init: stop=%b err=%b, want 0 0", stop_state, lp_err);
      end
      exp_q.push_back(ev(K_LP, 3'b111));
      exp_q.push_back(ev(K_SRISE, 3'd0));
      hold(3'b111, 6);
      total++;
      if (stop_state !== 1'b1) begin
         bad++; $display("FAIL illegal_recover: stop=%b, want 1", stop_state);
      end
      sb_flush("illegal");
   endtask

   task automatic enter_hs();
      exp_q.push_back(ev(K_LP, 3'b001));
      exp_q.push_back(ev(K_SFALL, 3'd0));
      hold(3'b001, 8);
      exp_q.push_back(ev(K_LP, 3'b000));
      exp_q.push_back(ev(K_HRISE, 3'd0));
      exp_q.push_back(ev(K_ENTRY, 3'd0));
      hold(3'b000, 16);
   endtask

   task automatic test_hs_immunity();
      enter_hs();
      exp_q.push_back(ev(K_LP, 3'b101));
      hold(3'b101, 10);
      hold(3'b011, 2);
      hold(3'b101, 4);
      total++;
      if (hs_rx_en !== 1'b1 || lp_state !== 3'b101) begin
         bad++; $display("FAIL hs_immunity: hs=%b lp=%b, want 1 101", hs_rx_en, lp_state);
      end
      sb_flush("immunity");
   endtask

   task automatic test_reset_enable_mid_hs();
      // Still in HS with lp_state 101 from the previous scenario.
      lp_in = 3'b111;
      rst_n = 1'b0;
      exp_q.push_back(ev(K_LP, 3'b111));
      exp_q.push_back(ev(K_HFALL, 3'd0));
      cyc();
      total++;
      if ({hs_rx_en, hs_exit_pulse, lp_state} !== 5'b00111) begin
         bad++;
         $display("FAIL rst_mid_hs: hs/exit/lp=%b, want 00111", {hs_rx_en, hs_exit_pulse, lp_state});
      end
      rst_n = 1'b1;
      exp_q.push_back(ev(K_SRISE, 3'd0));
      cyc();
      total++;
      if (stop_state !== 1'b1) begin
         bad++; $display("FAIL rst_recover: stop=%b, want 1", stop_state);
      end
      enter_hs();
      enable = 1'b0;
      exp_q.push_back(ev(K_HFALL, 3'd0));
      cyc();
      total++;
      if ({hs_rx_en, stop_state, hs_exit_pulse} !== 3'b000) begin
         bad++;
         $display("FAIL en_low: hs/stop/exit=%b, want 000", {hs_rx_en, stop_state, hs_exit_pulse});
      end
      exp_q.push_back(ev(K_LP, 3'b111));
      hold(3'b111, 5);
      total++;
      if (stop_state !== 1'b0) begin
         bad++; $display("FAIL en_low_held: stop=%b, want 0", stop_state);
      end
      enable = 1'b1;
      exp_q.push_back(ev(K_SRISE, 3'd0));
      cyc();
      total++;
      if (stop_state !== 1'b1) begin
         bad++; $display("FAIL reenable: stop=%b, want 1", stop_state);
      end
      sb_flush("rst_en");
   endtask

   // Bridge lengths around the settle boundary: 8 aborts on the terminal cycle, 9 enters.
   task automatic test_back_to_back();
      int k;
      for (int n = 0; n < 6; n++) begin
         k = (n == 0) ? 8 : (n == 1) ? 9 : int'($urandom_range(4, 16));
         exp_q.push_back(ev(K_LP, 3'b001));
         exp_q.push_back(ev(K_SFALL, 3'd0));
         hold(3'b001, int'($urandom_range(4, 8)));
         exp_q.push_back(ev(K_LP, 3'b000));
         if (k <= 8) begin
            exp_q.push_back(ev(K_LP, 3'b111));
            exp_q.push_back(ev(K_SRISE, 3'd0));
         end else begin
            if (k == 9) exp_q.push_back(ev(K_LP, 3'b111));
            exp_q.push_back(ev(K_HRISE, 3'd0));
            exp_q.push_back(ev(K_ENTRY, 3'd0));
            if (k != 9) exp_q.push_back(ev(K_LP, 3'b111));
            exp_q.push_back(ev(K_SRISE, 3'd0));
            exp_q.push_back(ev(K_HFALL, 3'd0));
            exp_q.push_back(ev(K_EXIT, 3'd0));
         end
         hold(3'b000, k);
         hold(3'b111, 8);
         total++;
         if (stop_state !== 1'b1 || hs_rx_en !== 1'b0) begin
            bad++;
            $display("FAIL b2b_k%0d: stop=%b hs=%b, want 1 0", k, stop_state, hs_rx_en);
         end
         sb_flush("b2b");
      end
   endtask

   initial begin
      test_reset();
      test_normal_entry();
      test_glitch();
      test_abort();
      test_illegal();
      test_hs_immunity();
      test_reset_enable_mid_hs();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
